// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: VGA timing constant sets and width helper shared by the raster generator.
package vga_timing_pkg;

    typedef struct packed {
        int h_area;
        int h_front;
        int h_sync;
        int h_back;
        int v_area;
        int v_front;
        int v_sync;
        int v_back;
    } vga_timing_t;

    localparam vga_timing_t VGA_640X480 = '{640, 16, 96, 48, 480, 10, 2, 33};
    localparam vga_timing_t VGA_800X600 = '{800, 40, 128, 88, 600, 1, 4, 23};

    // Never returns 0 so degenerate sizes still give a legal vector width.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/vga_span_counter.sv
// vga_span_counter: enable-qualified counter that wraps to zero after reaching limit.
module vga_span_counter #(
    parameter int W = 10
) (
    input  logic         VGA_CLK,
    input  logic         RST,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic [W-1:0] count,
    output logic         wrap
);

    logic [W-1:0] count_q, count_d;

    assign wrap    = en && count_q == limit;
    assign count_d = wrap ? '0 : en ? count_q + 1'b1 : count_q;
    assign count   = count_q;

    always_ff @(posedge VGA_CLK) begin
        if (RST) count_q <= '0;
        else     count_q <= count_d;
    end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: registered VGA raster timing with sync, active flag, coordinates and strobes.
// Define VGA_TIMING_ADDR_EN to add the P_COUNT linear frame-buffer address output.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_AREA  = VGA_640X480.h_area,
    parameter int H_FRONT = VGA_640X480.h_front,
    parameter int H_SYNC  = VGA_640X480.h_sync,
    parameter int H_BACK  = VGA_640X480.h_back,
    parameter int V_AREA  = VGA_640X480.v_area,
    parameter int V_FRONT = VGA_640X480.v_front,
    parameter int V_SYNC  = VGA_640X480.v_sync,
    parameter int V_BACK  = VGA_640X480.v_back,
    parameter bit HS_POL  = 1'b0,
    parameter bit VS_POL  = 1'b0,
    parameter int FRAME_W = 8,
    localparam int H_WHOLE = H_AREA + H_FRONT + H_SYNC + H_BACK,
    localparam int V_WHOLE = V_AREA + V_FRONT + V_SYNC + V_BACK,
    localparam int H_W     = clog2(H_WHOLE),
    localparam int V_W     = clog2(V_WHOLE),
    localparam int ADDR_W  = clog2(H_AREA * V_AREA)
) (
    input  logic               VGA_CLK,
    input  logic               RST,
    input  logic               CE,
    output logic               PIXEL,
    output logic               VGA_HS,
    output logic               VGA_VS,
    output logic [H_W-1:0]     H_POS,
    output logic [V_W-1:0]     V_POS,
`ifdef VGA_TIMING_ADDR_EN
    output logic [ADDR_W-1:0]  P_COUNT,
`endif
    output logic               LINE_START,
    output logic               FRAME_START,
    output logic [FRAME_W-1:0] FRAME_CNT
);

    logic [H_W-1:0] h_q;
    logic [V_W-1:0] v_q;
    logic h_wrap, v_wrap, act, hs_on, vs_on, origin;

    vga_span_counter #(.W(H_W)) u_h (
        .VGA_CLK(VGA_CLK), .RST(RST), .en(CE), .limit(H_W'(H_WHOLE - 1)),
        .count(h_q), .wrap(h_wrap)
    );

    vga_span_counter #(.W(V_W)) u_v (
        .VGA_CLK(VGA_CLK), .RST(RST), .en(CE && h_wrap), .limit(V_W'(V_WHOLE - 1)),
        .count(v_q), .wrap(v_wrap)
    );

    assign act    = int'(h_q) < H_AREA && int'(v_q) < V_AREA;
    assign hs_on  = int'(h_q) >= H_AREA + H_FRONT && int'(h_q) < H_AREA + H_FRONT + H_SYNC;
    assign vs_on  = int'(v_q) >= V_AREA + V_FRONT && int'(v_q) < V_AREA + V_FRONT + V_SYNC;
    assign origin = h_q == '0 && v_q == '0;

    logic               pixel_q, pixel_d, hs_q, hs_d, vs_q, vs_d;
    logic               ls_q, ls_d, fs_q, fs_d, wrapped_q, wrapped_d;
    logic [H_W-1:0]     h_pos_q, h_pos_d;
    logic [V_W-1:0]     v_pos_q, v_pos_d;
    logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;

    // wrapped_q marks that a whole frame finished, so the origin that follows
    // reset is not counted but every later one is.
    always_comb begin
        pixel_d     = CE ? act : pixel_q;
        hs_d        = CE ? (hs_on ? HS_POL : !HS_POL) : hs_q;
        vs_d        = CE ? (vs_on ? VS_POL : !VS_POL) : vs_q;
        h_pos_d     = CE ? h_q : h_pos_q;
        v_pos_d     = CE ? v_q : v_pos_q;
        ls_d        = CE && h_q == '0;
        fs_d        = CE && origin;
        frame_cnt_d = (CE && origin) ? frame_cnt_q + FRAME_W'(wrapped_q) : frame_cnt_q;
        wrapped_d   = v_wrap ? 1'b1 : (CE && origin) ? 1'b0 : wrapped_q;
    end

    always_ff @(posedge VGA_CLK) begin
        if (RST) begin
            pixel_q     <= 1'b0;
            hs_q        <= !HS_POL;
            vs_q        <= !VS_POL;
            h_pos_q     <= '0;
            v_pos_q     <= '0;
            ls_q        <= 1'b0;
            fs_q        <= 1'b0;
            frame_cnt_q <= '0;
            wrapped_q   <= 1'b0;
        end else begin
            pixel_q     <= pixel_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            h_pos_q     <= h_pos_d;
            v_pos_q     <= v_pos_d;
            ls_q        <= ls_d;
            fs_q        <= fs_d;
            frame_cnt_q <= frame_cnt_d;
            wrapped_q   <= wrapped_d;
        end
    end

    assign PIXEL       = pixel_q;
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign H_POS       = h_pos_q;
    assign V_POS       = v_pos_q;
    assign LINE_START  = ls_q;
    assign FRAME_START = fs_q;
    assign FRAME_CNT   = frame_cnt_q;

`ifdef VGA_TIMING_ADDR_EN
    // addr_q is the address of the next active pixel; origin is itself active, so it restarts at 1.
    logic [ADDR_W-1:0] addr_q, addr_d, p_count_q, p_count_d;

    always_comb begin
        addr_d    = !CE ? addr_q : origin ? ADDR_W'(1) : act ? addr_q + 1'b1 : addr_q;
        p_count_d = !CE ? p_count_q : origin ? '0 : act ? addr_q : p_count_q;
    end

    always_ff @(posedge VGA_CLK) begin
        if (RST) begin
            addr_q    <= '0;
            p_count_q <= '0;
        end else begin
            addr_q    <= addr_d;
            p_count_q <= p_count_d;
        end
    end

    assign P_COUNT = p_count_q;
`endif

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator. Produces horizontal/vertical sync, an active-video flag, pixel coordinates, a linear frame-buffer address and frame/line strobes from a single pixel clock with an optional clock-enable. It sits between the pixel clock source and the frame-buffer read port / colour output stage. All outputs are registered and mutually aligned.

## Interface

Parameters:
- H_AREA, 640: active pixels per line
- H_FRONT, 16: horizontal front porch, in pixels
- H_SYNC, 96: horizontal sync width, in pixels
- H_BACK, 48: horizontal back porch, in pixels
- V_AREA, 480: active lines per frame
- V_FRONT, 10: vertical front porch, in lines
- V_SYNC, 2: vertical sync width, in lines
- V_BACK, 33: vertical back porch, in lines
- HS_POL, 0: HS asserted level (0 = active-low)
- VS_POL, 0: VS asserted level (0 = active-low)
- FRAME_W, 8: width of the frame counter

Derived values:
- H_WHOLE = sum of the four H terms; V_WHOLE likewise.
- H_W = clog2(H_WHOLE); V_W = clog2(V_WHOLE); ADDR_W = clog2(H_AREA*V_AREA).

Ports:
- VGA_CLK, in, 1: pixel clock. This is the only clock.
- RST, in, 1: synchronous, active-high reset.
- CE, in, 1: pixel enable. The raster advances only on edges where CE=1.
- PIXEL, out, 1: 1 while inside the active area.
- VGA_HS, out, 1: horizontal sync, at the HS_POL level when asserted.
- VGA_VS, out, 1: vertical sync, at the VS_POL level when asserted.
- H_POS, out, H_W: current column, 0..H_WHOLE-1.
- V_POS, out, V_W: current line, 0..V_WHOLE-1.
- P_COUNT, out, ADDR_W: linear frame-buffer address. Present only with VGA_TIMING_ADDR_EN.
- LINE_START, out, 1: one-clock pulse at H_POS=0.
- FRAME_START, out, 1: one-clock pulse at position (0,0).
- FRAME_CNT, out, FRAME_W: count of completed frames. Wraps modulo 2^FRAME_W.

## Operation

Counters:
- Internal counters h and v.
- On each CE=1 edge, h increments. At h = H_WHOLE-1, h wraps to 0.
- v increments only on the edge where h wraps. v wraps to 0 only when h = H_WHOLE-1 and v = V_WHOLE-1 in the same cycle.

Output decode (applied to the counter values):
- PIXEL = (h < H_AREA) && (v < V_AREA).
- HS is asserted for H_AREA+H_FRONT ≤ h < H_AREA+H_FRONT+H_SYNC.
- VS is asserted for V_AREA+V_FRONT ≤ v < V_AREA+V_FRONT+V_SYNC.

P_COUNT:
- Implemented as an incrementing counter. No multiplier.
- Advances by 1 after each active pixel.
- Holds its value through blanking.
- Clears to 0 at (0,0).
- Invariant: whenever PIXEL=1, P_COUNT = V_POS*H_AREA + H_POS.

FRAME_CNT increments when the output stage presents (0,0), except on the first presentation after reset.

CE=0 cycles:
- All state holds.
- LINE_START and FRAME_START are forced to 0, so each strobe lasts exactly one VGA_CLK cycle.

Reset values:
- h = 0, v = 0.
- PIXEL = 0.
- VGA_HS = !HS_POL, VGA_VS = !VS_POL.
- H_POS = 0, V_POS = 0.
- P_COUNT = 0, FRAME_CNT = 0.
- LINE_START = 0, FRAME_START = 0.

RST asserted mid-frame:
- Takes effect on the next edge, regardless of CE.
- Raster restarts at (0,0). No partial-frame strobe is emitted.

## Timing

- Output latency: one CE-qualified edge. On a CE=1 edge, the output registers load the decode of the current (h,v) while the counters advance.
- First CE=1 edge after reset release: outputs show (0,0) with PIXEL=1, FRAME_START=1, LINE_START=1, FRAME_CNT=0.
- With CE tied to 1, the period is H_WHOLE clocks per line and H_WHOLE*V_WHOLE clocks per frame. Defaults: 800 and 420000.
- All outputs change on the same edge. No output has a combinational path from an input.

## Configuration

- VGA_TIMING_ADDR_EN defined: the P_COUNT port and its counter exist.
- VGA_TIMING_ADDR_EN undefined: the port and its logic are removed. All other outputs and timing are unchanged.

## Structure

- Package vga_timing_pkg holds:
  - the 640x480@60 default timing constants;
  - a clog2 helper function;
  - an 800x600 alternate timing constant set.
- Sub-module vga_span_counter: a parametrised wrap counter with inputs en, RST and limit, and outputs count and wrap. It is instantiated twice: h is enabled by CE, v is enabled by CE && h-wrap.

## Test plan

- Reset: hold RST 5 cycles with CE=1 → all outputs at reset values; VGA_HS=1 and VGA_VS=1 with default polarity.
- Default line, CE=1: VGA_HS low for exactly 96 clocks starting at H_POS=656; PIXEL high for 640 clocks per line; LINE_START every 800 clocks.
- Default frame: VGA_VS low for lines 490-491 (1600 clocks); FRAME_START every 420000 clocks; FRAME_CNT goes 0 → 1 → 2 over three frames.
- CE toggling 1,0,1,0: frame period becomes 840000 clocks; strobes remain single-cycle; outputs hold on CE=0.
- Small parameters (H 4/1/1/1, V 3/1/1/1), ADDR_EN defined: P_COUNT takes values 0..11 during PIXEL=1, returns to 0 at the next FRAME_START; HS_POL=1 gives an active-high sync.
- Reset asserted at H_POS=300, V_POS=200: next CE edge gives (0,0) output with FRAME_CNT=0 and P_COUNT=0.
